sdc_host_arb: RTL and testbench

- N-port round-robin arbiter in front of the SDRAM controller host port (sdc_top's sdr_* interface).
- Lets several masters (video DMA, CPU, etc.) share one controller.
- Latches one requester's command, presents it to the controller, and routes the write-data handshake and read-data beats back to the owner until the burst completes. Only then does it re-arbitrate.

---
 rtl/sdc_host_arb_pkg.sv | 9 +
 rtl/sdc_rr_pick.sv | 30 +++
 rtl/sdc_host_arb.sv | 139 +++++++++++++
 tb/tb_sdc_host_arb.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_host_arb_pkg.sv
// sdc_host_arb_pkg: shared FSM encodings, burst decode and default widths for the SDRAM host arbiter
package sdc_host_arb_pkg;
    localparam int ADDR_W_DEF = 26;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} arb_state_e;
    function automatic logic [3:0] burst_beats(input logic [1:0] len);
        return 4'd1 << len;
    endfunction
endpackage

// File: rtl/sdc_rr_pick.sv
// sdc_rr_pick: combinational one-hot round-robin picker; prio_en makes requester 0 a fixed top priority
module sdc_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   ptr,
    input  logic         prio_en,
    output logic [N-1:0] gnt,
    output logic [2:0]   idx
);
    // later writes win: lowest index above ptr beats anything at or below it
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i] && i <= int'(ptr) && !(prio_en && i == 0)) begin
                gnt = N'(1) << i;
                idx = 3'(i);
            end
        for (int i = N - 1; i >= 0; i--)
            if (req[i] && i > int'(ptr) && !(prio_en && i == 0)) begin
                gnt = N'(1) << i;
                idx = 3'(i);
            end
        if (prio_en && req[0]) begin
            gnt = N'(1);
            idx = '0;
        end
    end
endmodule

// File: rtl/sdc_host_arb.sv
// sdc_host_arb: N-port round-robin arbiter in front of the SDRAM controller host port
// Define SDC_ARB_PRIO_EN to give master 0 fixed highest priority over the rotating others.
module sdc_host_arb
    import sdc_host_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                   mclk,
    input  logic                   s_reset,
    input  logic [NREQ-1:0]        m_req,
    input  logic [NREQ*ADDR_W-1:0] m_adr,
    input  logic [NREQ*2-1:0]      m_len,
    input  logic [NREQ-1:0]        m_wr_n,
    input  logic [NREQ*DATA_W-1:0] m_wr_data,
    input  logic [NREQ*4-1:0]      m_wr_en_n,
    output logic [NREQ-1:0]        m_ack,
    output logic [NREQ-1:0]        m_wr_next,
    output logic [NREQ-1:0]        m_rd_valid,
    output logic [DATA_W-1:0]      m_rd_data,
    output logic                   sdr_req,
    output logic [ADDR_W-1:0]      sdr_req_adr,
    output logic [1:0]             sdr_req_len,
    output logic                   sdr_req_wr_n,
    output logic [DATA_W-1:0]      sdr_wr_data,
    output logic [3:0]             sdr_wr_en_n,
    input  logic                   sdr_req_ack,
    input  logic                   sdr_wr_next,
    input  logic                   sdr_rd_valid,
    input  logic [DATA_W-1:0]      sdr_rd_data,
    input  logic                   sdr_init_done,
    output logic [2:0]             grant_id
);
    arb_state_e        state;
    logic [2:0]        ptr;
    logic [3:0]        cnt;
    logic [NREQ-1:0]   owner_oh;
    logic              err_stray;
    logic [NREQ-1:0]   pick_gnt;
    logic [2:0]        pick_idx;
    logic              prio_en;
    logic [ADDR_W-1:0] sel_adr;
    logic [1:0]        sel_len;
    logic              sel_wr_n;
    logic [DATA_W-1:0] own_data;
    logic [3:0]        own_en;
    logic              active, wr_beat, rd_beat;

`ifdef SDC_ARB_PRIO_EN
    assign prio_en = 1'b1;
`else
    assign prio_en = 1'b0;
`endif

    sdc_rr_pick #(.N(NREQ)) u_pick (
        .req     (m_req),
        .ptr     (ptr),
        .prio_en (prio_en),
        .gnt     (pick_gnt),
        .idx     (pick_idx)
    );

    always_comb begin
        sel_adr  = '0;
        sel_len  = '0;
        sel_wr_n = 1'b1;
        own_data = '0;
        own_en   = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_adr  = m_adr[i*ADDR_W +: ADDR_W];
                sel_len  = m_len[i*2 +: 2];
                sel_wr_n = m_wr_n[i];
            end
            if (owner_oh[i]) begin
                own_data = m_wr_data[i*DATA_W +: DATA_W];
                own_en   = m_wr_en_n[i*4 +: 4];
            end
        end
    end

    // write beats may arrive together with the ack, read beats only once in DATA
    assign active      = state != IDLE;
    assign wr_beat     = active && !sdr_req_wr_n && sdr_wr_next;
    assign rd_beat     = state == DATA && sdr_req_wr_n && sdr_rd_valid;
    assign m_ack       = (state == CMD && sdr_req_ack) ? owner_oh : '0;
    assign m_wr_next   = wr_beat ? owner_oh : '0;
    assign m_rd_valid  = rd_beat ? owner_oh : '0;
    assign m_rd_data   = sdr_rd_data;
    assign sdr_wr_data = active ? own_data : '0;
    assign sdr_wr_en_n = active ? own_en : 4'hF;

    always_ff @(posedge mclk or posedge s_reset) begin
        if (s_reset) begin
            state        <= IDLE;
            ptr          <= 3'(NREQ - 1);
            cnt          <= '0;
            owner_oh     <= '0;
            grant_id     <= '0;
            err_stray    <= 1'b0;
            sdr_req      <= 1'b0;
            sdr_req_adr  <= '0;
            sdr_req_len  <= '0;
            sdr_req_wr_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (sdr_rd_valid || sdr_wr_next) err_stray <= 1'b1;
                    if (sdr_init_done && |pick_gnt) begin
                        owner_oh     <= pick_gnt;
                        grant_id     <= pick_idx;
                        sdr_req_adr  <= sel_adr;
                        sdr_req_len  <= sel_len;
                        sdr_req_wr_n <= sel_wr_n;
                        cnt          <= burst_beats(sel_len);
                        sdr_req      <= 1'b1;
                        state        <= CMD;
                    end
                end
                CMD: begin
                    if (wr_beat) cnt <= cnt - 4'd1;
                    if (sdr_req_ack) begin
                        sdr_req <= 1'b0;
                        state   <= (wr_beat && cnt == 4'd1) ? IDLE : DATA;
                        if (!(prio_en && grant_id == 3'd0)) ptr <= grant_id;
                    end
                end
                DATA: begin
                    if (wr_beat || rd_beat) begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdc_host_arb.sv
// tb_sdc_host_arb: directed scoreboard bench for sdc_host_arb, with a small controller model
module tb_sdc_host_arb;
    localparam int N  = 4;
    localparam int AW = 26;
    localparam int DW = 32;

    logic            mclk = 1'b0;
    logic            s_reset;
    logic [N-1:0]    m_req;
    logic [N*AW-1:0] m_adr;
    logic [N*2-1:0]  m_len;
    logic [N-1:0]    m_wr_n;
    logic [N*DW-1:0] m_wr_data;
    logic [N*4-1:0]  m_wr_en_n;
    logic [N-1:0]    m_ack, m_wr_next, m_rd_valid;
    logic [DW-1:0]   m_rd_data;
    logic            sdr_req;
    logic [AW-1:0]   sdr_req_adr;
    logic [1:0]      sdr_req_len;
    logic            sdr_req_wr_n;
    logic [DW-1:0]   sdr_wr_data;
    logic [3:0]      sdr_wr_en_n;
    logic            sdr_req_ack, sdr_wr_next, sdr_rd_valid, sdr_init_done;
    logic [DW-1:0]   sdr_rd_data;
    logic [2:0]      grant_id;

    always #5 mclk = ~mclk;

    sdc_host_arb #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .mclk(mclk), .s_reset(s_reset),
        .m_req(m_req), .m_adr(m_adr), .m_len(m_len), .m_wr_n(m_wr_n),
        .m_wr_data(m_wr_data), .m_wr_en_n(m_wr_en_n),
        .m_ack(m_ack), .m_wr_next(m_wr_next), .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
        .sdr_req(sdr_req), .sdr_req_adr(sdr_req_adr), .sdr_req_len(sdr_req_len),
        .sdr_req_wr_n(sdr_req_wr_n), .sdr_wr_data(sdr_wr_data), .sdr_wr_en_n(sdr_wr_en_n),
        .sdr_req_ack(sdr_req_ack), .sdr_wr_next(sdr_wr_next), .sdr_rd_valid(sdr_rd_valid),
        .sdr_rd_data(sdr_rd_data), .sdr_init_done(sdr_init_done), .grant_id(grant_id)
    );

    typedef struct {
        int          own;
        logic [AW-1:0] adr;
        logic [1:0]  len;
        logic        wr_n;
        bit          drop;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   last_wait;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_burst(input int own, input bit drop);
        exp_t e;
        e.own  = own;
        e.adr  = m_adr[own*AW +: AW];
        e.len  = m_len[own*2 +: 2];
        e.wr_n = m_wr_n[own];
        e.drop = drop;
        sb.push_back(e);
    endtask

    // controller model: wait for sdr_req, ack it, then deliver `give` beats
    task automatic serve(input int give);
        exp_t e;
        int n;
        logic [DW-1:0] d;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = sb.pop_front();
        n = 0;
        @(negedge mclk);
        while (!sdr_req && n < 20) begin
            @(negedge mclk);
            n++;
        end
        last_wait = n;
        check("sdr_req_seen", sdr_req, 1);
        if (!sdr_req) return;
        check("grant_id", grant_id, e.own);
        check("sdr_req_adr", sdr_req_adr, e.adr);
        check("sdr_req_len", sdr_req_len, e.len);
        check("sdr_req_wr_n", sdr_req_wr_n, e.wr_n);
        sdr_req_ack = 1'b1;
        #1;
        check("m_ack", m_ack, 64'(1) << e.own);
        @(posedge mclk);
        #1;
        sdr_req_ack = 1'b0;
        if (e.drop) m_req[e.own] = 1'b0;
        check("m_ack_pulse", m_ack, 0);
        for (int b = 0; b < give; b++) begin
            @(negedge mclk);
            if (!e.wr_n) begin
                d = 32'hA500_0000 | 32'(b);
                m_wr_data[e.own*DW +: DW] = d;
                m_wr_en_n[e.own*4 +: 4]   = 4'(b);
                sdr_wr_next = 1'b1;
                #1;
                check("m_wr_next", m_wr_next, 64'(1) << e.own);
                check("sdr_wr_data", sdr_wr_data, d);
                check("sdr_wr_en_n", sdr_wr_en_n, 4'(b));
                check("m_rd_valid_on_wr", m_rd_valid, 0);
            end else begin
                d = $urandom;
                sdr_rd_data  = d;
                sdr_rd_valid = 1'b1;
                #1;
                check("m_rd_valid", m_rd_valid, 64'(1) << e.own);
                check("m_rd_data", m_rd_data, d);
                check("m_wr_next_on_rd", m_wr_next, 0);
            end
            @(posedge mclk);
            #1;
            sdr_wr_next  = 1'b0;
            sdr_rd_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        s_reset = 1'b1;
        m_req = '0;
        m_wr_n = '1;
        m_len = '0;
        m_wr_data = '0;
        m_wr_en_n = '1;
        for (int i = 0; i < N; i++) m_adr[i*AW +: AW] = AW'(32'h100 * i + i);
        sdr_req_ack = 1'b0;
        sdr_wr_next = 1'b0;
        sdr_rd_valid = 1'b0;
        sdr_rd_data = '0;
        sdr_init_done = 1'b0;
        repeat (3) @(posedge mclk);
        @(negedge mclk);
        check("rst_sdr_req", sdr_req, 0);
        check("rst_sdr_req_wr_n", sdr_req_wr_n, 1);
        check("rst_sdr_wr_en_n", sdr_wr_en_n, 4'hF);
        check("rst_grant_id", grant_id, 0);
        check("rst_m_ack", m_ack, 0);
        @(posedge mclk);
        #1;
        s_reset = 1'b0;

        // init_done low blocks every grant
        m_req = 4'b1111;
        seen = 1'b0;
        repeat (50) begin
            @(negedge mclk);
            if (sdr_req) seen = 1'b1;
        end
        check("init_hold", seen, 0);
        @(posedge mclk);
        #1;
        sdr_init_done = 1'b1;
        @(negedge mclk);
        check("pre_grant", sdr_req, 0);

        // continuous 1-beat reads from all four masters
        for (int i = 0; i < 8; i++) begin
`ifdef SDC_ARB_PRIO_EN
            expect_burst(0, 1'b0);
`else
            expect_burst(i % N, 1'b0);
`endif
        end
        for (int i = 0; i < 8; i++) begin
            serve(1);
            check(i == 0 ? "first_latency" : "idle_gap", last_wait, i == 0 ? 0 : 1);
        end
        m_req = '0;

        // master 2: 8-beat write at 0x0001230
        m_adr[2*AW +: AW] = 26'h0001230;
        m_len[2*2 +: 2]   = 2'b11;
        m_wr_n[2]         = 1'b0;
        expect_burst(2, 1'b1);
        m_req[2] = 1'b1;
        serve(8);
        check("err_stray_clear", dut.err_stray, 0);

        // stray beats in IDLE right after the burst: no 9th pulse, flag sets
        @(negedge mclk);
        sdr_wr_next  = 1'b1;
        sdr_rd_valid = 1'b1;
        #1;
        check("stray_wr_next", m_wr_next, 0);
        check("stray_rd_valid", m_rd_valid, 0);
        @(posedge mclk);
        #1;
        sdr_wr_next  = 1'b0;
        sdr_rd_valid = 1'b0;
        check("err_stray_set", dut.err_stray, 1);
        m_wr_n[2] = 1'b1;

        // reset mid 4-beat read after 2 beats
        m_adr[1*AW +: AW] = 26'h3ABCDE0;
        m_len[1*2 +: 2]   = 2'b10;
        expect_burst(1, 1'b0);
        m_req[1] = 1'b1;
        serve(2);
        @(negedge mclk);
        s_reset      = 1'b1;
        sdr_rd_valid = 1'b1;
        #1;
        check("mid_rst_rd_valid", m_rd_valid, 0);
        check("mid_rst_grant_id", grant_id, 0);
        check("mid_rst_adr", sdr_req_adr, 0);
        check("mid_rst_len", sdr_req_len, 0);
        check("mid_rst_wr_n", sdr_req_wr_n, 1);
        check("mid_rst_en_n", sdr_wr_en_n, 4'hF);
        check("mid_rst_err_stray", dut.err_stray, 0);
        @(posedge mclk);
        #1;
        sdr_rd_valid = 1'b0;
        s_reset      = 1'b0;
        expect_burst(1, 1'b1);
        serve(4);
        @(negedge mclk);
        sdr_rd_valid = 1'b1;
        #1;
        check("no_fifth_beat", m_rd_valid, 0);
        @(posedge mclk);
        #1;
        sdr_rd_valid = 1'b0;

`ifdef SDC_ARB_PRIO_EN
        // master 0 starves master 3 until it lets go
        m_len = '0;
        expect_burst(0, 1'b0);
        expect_burst(0, 1'b0);
        expect_burst(0, 1'b1);
        expect_burst(3, 1'b1);
        m_req = 4'b1001;
        repeat (4) serve(1);
`endif

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
